// File: rtl/sram_port_arbiter.sv
// Arbitrates fetch (read-only) and data (rd/wr) ports onto one SRAM controller; data wins, fetch forced after STARVE_LIMIT data wins.
// Latency: 1 cycle arbitration + 1 IDLE gap between accesses; backpressure: level ready held low until the controller completes.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd_en,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [63:0] i_rdata,
  input  logic        d_rd_en,
  input  logic        d_wr_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [63:0] d_rdata,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready,
  output logic        busy,
  output logic        grant_d
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  localparam int            CW        = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT     = CW'(STARVE_LIMIT);
  localparam logic          GUARD_EN  = (STARVE_LIMIT != 0);

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          d_req;
  logic          force_i;

  assign d_req   = d_rd_en | d_wr_en;
  assign force_i = GUARD_EN & (starve_cnt == LIMIT) & i_rd_en;

  // Ready is a stall level: an idle port never stalls, a requesting port only sees its completion cycle.
  assign i_ready = ~i_rd_en | ((state == GRANT_I) & sram_ready);
  assign d_ready = ~d_req   | ((state == GRANT_D) & sram_ready);
  assign i_rdata = sram_rdata;
  assign d_rdata = sram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sram_read_en  <= 1'b0;
      sram_write_en <= 1'b0;
      sram_address  <= '0;
      sram_wdata    <= '0;
      busy          <= 1'b0;
      grant_d       <= 1'b0;
      starve_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (force_i || (!d_req && i_rd_en)) begin
            state         <= GRANT_I;
            sram_read_en  <= 1'b1;
            sram_write_en <= 1'b0;
            sram_address  <= i_addr;
            busy          <= 1'b1;
            grant_d       <= 1'b0;
            starve_cnt    <= '0;
          end else if (d_req) begin
            // A write request takes precedence over a simultaneous read on the data port.
            state         <= GRANT_D;
            sram_read_en  <= ~d_wr_en;
            sram_write_en <= d_wr_en;
            sram_address  <= d_addr;
            sram_wdata    <= d_wdata;
            busy          <= 1'b1;
            grant_d       <= 1'b1;
            if (i_rd_en && (starve_cnt != LIMIT)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          if (sram_ready) begin
            state         <= IDLE;
            sram_read_en  <= 1'b0;
            sram_write_en <= 1'b0;
            busy          <= 1'b0;
            grant_d       <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          sram_read_en  <= 1'b0;
          sram_write_en <= 1'b0;
          busy          <= 1'b0;
          grant_d       <= 1'b0;
        end
      endcase
    end
  end

endmodule
